ws2812_rx_decoder: RTL and testbench

Receives a WS2812 single-wire serial stream, measures high-pulse widths to recover bits, and assembles 24-bit GRB words into R/G/B pixels with a per-frame LED address. It detects the long-low reset gap as a frame boundary and flags malformed symbols. It sits on a cape input pin and serves as loopback/verification monitor for our strip driver, or as a pixel source when a WS2812 controller drives the cape.

---
 rtl/ws2812_pkg.sv | 31 +++
 rtl/ws2812_rx_sync.sv | 34 +++
 rtl/ws2812_rx_decoder.sv | 164 ++++++++++++++++
 tb/tb_ws2812_rx_decoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, error codes and the
// default 50 MHz pulse timing also used by the strip driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_GLITCH     = 2'd0,
        ERR_STUCK_HIGH = 2'd1,
        ERR_PARTIAL    = 2'd2,
        ERR_OVERFLOW   = 2'd3
    } rx_err_t;

    localparam int unsigned DEF_LED_COUNT        = 512;
    localparam int unsigned DEF_CYCLES_THRESHOLD = 31;
    localparam int unsigned DEF_CYCLES_MIN_HIGH  = 5;
    localparam int unsigned DEF_CYCLES_MAX_HIGH  = 100;
    localparam int unsigned DEF_CYCLES_RESET     = 2500;

    localparam int unsigned CNT_W = 12;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Brings the asynchronous data pin into the led_clk_i domain and derives
// single-cycle rise/fall pulses from the synchronised level.
module ws2812_rx_sync (
    input  logic led_clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1;
    logic s2;
    logic s3;

    // NOTE: sequential state uses non-blocking assignments so the three
    // flops shift together instead of collapsing into one.
    always_ff @(posedge led_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= data_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level_o = s2;
    assign rise_o  = s2 & ~s3;
    assign fall_o  = ~s2 & s3;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 receiver: measures high-pulse widths, assembles GRB words into
// pixels with a per-frame address, and reports frame gaps and bad symbols.
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int unsigned LED_COUNT        = DEF_LED_COUNT,
    parameter int unsigned CYCLES_THRESHOLD = DEF_CYCLES_THRESHOLD,
    parameter int unsigned CYCLES_MIN_HIGH  = DEF_CYCLES_MIN_HIGH,
    parameter int unsigned CYCLES_MAX_HIGH  = DEF_CYCLES_MAX_HIGH,
    parameter int unsigned CYCLES_RESET     = DEF_CYCLES_RESET
) (
    input  logic       led_clk_i,
    input  logic       rst_n_i,
    input  logic       led_data_i,
    output logic [7:0] pixel_r_o,
    output logic [7:0] pixel_g_o,
    output logic [7:0] pixel_b_o,
    output logic [8:0] led_address_o,
    output logic       led_address_valid_o,
    output logic       frame_end_o,
    output logic [9:0] frame_pixels_o,
    output logic       error_o,
    output logic [1:0] error_code_o
);

    localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(CYCLES_THRESHOLD);
    localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(CYCLES_MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(CYCLES_MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_CNT  = CNT_W'(CYCLES_RESET);
    localparam logic [9:0]       LED_LIMIT  = 10'(LED_COUNT);

    logic level;
    logic rise;
    logic fall;

    ws2812_rx_sync u_sync (
        .led_clk_i (led_clk_i),
        .rst_n_i   (rst_n_i),
        .data_i    (led_data_i),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    rx_state_t        state;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [4:0]       bit_cnt;
    logic [23:0]      shift;
    logic [9:0]       addr;

    logic        bit_val;
    logic [23:0] shift_next;

    assign bit_val    = (high_cnt >= THRESH_CNT);
    assign shift_next = {shift[22:0], bit_val};

    always_ff @(posedge led_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state               <= ST_SYNC;
            high_cnt            <= '0;
            low_cnt             <= '0;
            bit_cnt             <= '0;
            shift               <= '0;
            addr                <= '0;
            pixel_r_o           <= '0;
            pixel_g_o           <= '0;
            pixel_b_o           <= '0;
            led_address_o       <= '0;
            led_address_valid_o <= 1'b0;
            frame_end_o         <= 1'b0;
            frame_pixels_o      <= '0;
            error_o             <= 1'b0;
            error_code_o        <= '0;
        end else begin
            // Strobes idle low; the branch that raises one holds it a single cycle.
            led_address_valid_o <= 1'b0;
            frame_end_o         <= 1'b0;
            error_o             <= 1'b0;

            unique case (state)
                ST_SYNC: begin
                    if (level) begin
                        low_cnt <= '0;
                    end else if (low_cnt == RESET_CNT) begin
                        state   <= ST_IDLE;
                        addr    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        low_cnt <= sat_inc(low_cnt);
                    end
                end

                ST_IDLE: begin
                    if (rise) begin
                        state    <= ST_HIGH;
                        high_cnt <= CNT_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (high_cnt == MAX_CNT) begin
                        error_o      <= 1'b1;
                        error_code_o <= ERR_STUCK_HIGH;
                        low_cnt      <= '0;
                        state        <= ST_SYNC;
                    end else if (fall) begin
                        if (high_cnt < MIN_CNT) begin
                            error_o      <= 1'b1;
                            error_code_o <= ERR_GLITCH;
                            low_cnt      <= '0;
                            state        <= ST_SYNC;
                        end else begin
                            shift   <= shift_next;
                            low_cnt <= CNT_W'(1);
                            state   <= ST_LOW;
                            if (bit_cnt == 5'd23) begin
                                // Wire order is G, R, B, each MSB first.
                                if (addr < LED_LIMIT) begin
                                    pixel_g_o           <= shift_next[23:16];
                                    pixel_r_o           <= shift_next[15:8];
                                    pixel_b_o           <= shift_next[7:0];
                                    led_address_o       <= addr[8:0];
                                    led_address_valid_o <= 1'b1;
                                end else begin
                                    error_o      <= 1'b1;
                                    error_code_o <= ERR_OVERFLOW;
                                end
                                addr    <= (&addr) ? addr : addr + 1'b1;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        high_cnt <= sat_inc(high_cnt);
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        state    <= ST_HIGH;
                        high_cnt <= CNT_W'(1);
                    end else if (low_cnt == RESET_CNT) begin
                        frame_end_o    <= 1'b1;
                        frame_pixels_o <= addr;
                        addr           <= '0;
                        bit_cnt        <= '0;
                        state          <= ST_IDLE;
                        if (bit_cnt != '0) begin
                            error_o      <= 1'b1;
                            error_code_o <= ERR_PARTIAL;
                        end
                    end else begin
                        low_cnt <= sat_inc(low_cnt);
                    end
                end

                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Drives encoded WS2812 pulse trains into two decoder instances (full size
// and LED_COUNT=2) and checks their events against a pixel-level model.
module tb_ws2812_rx_decoder;

    localparam int DUT_LEDS   = 512;
    localparam int SMALL_LEDS = 2;
    localparam int GAP        = 2600;

    typedef struct {
        int          cyc;
        logic [8:0]  addr;
        logic [23:0] rgb;
    } px_t;

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic led_data;
    int   cyc = 0;

    logic [7:0] r, g, b, s_r, s_g, s_b;
    logic [8:0] addr, s_addr;
    logic       valid, fe, err, s_valid, s_fe, s_err;
    logic [9:0] fp, s_fp;
    logic [1:0] code, s_code;

    int checks   = 0;
    int failures = 0;

    px_t px_q[$], s_px_q[$], exp_px[$];
    ev_t fe_q[$], er_q[$], s_fe_q[$], s_er_q[$];
    int  exp_fe[$];
    int  frame_n;
    int  last_fall_cyc;
    px_t mon_px;
    ev_t mon_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_rx_decoder dut (
        .led_clk_i(clk), .rst_n_i(rst_n), .led_data_i(led_data),
        .pixel_r_o(r), .pixel_g_o(g), .pixel_b_o(b),
        .led_address_o(addr), .led_address_valid_o(valid),
        .frame_end_o(fe), .frame_pixels_o(fp),
        .error_o(err), .error_code_o(code)
    );

    ws2812_rx_decoder #(.LED_COUNT(SMALL_LEDS)) dut_small (
        .led_clk_i(clk), .rst_n_i(rst_n), .led_data_i(led_data),
        .pixel_r_o(s_r), .pixel_g_o(s_g), .pixel_b_o(s_b),
        .led_address_o(s_addr), .led_address_valid_o(s_valid),
        .frame_end_o(s_fe), .frame_pixels_o(s_fp),
        .error_o(s_err), .error_code_o(s_code)
    );

    // Event monitor, sampling on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                mon_px.cyc = cyc; mon_px.addr = addr; mon_px.rgb = {r, g, b};
                px_q.push_back(mon_px);
            end
            if (s_valid) begin
                mon_px.cyc = cyc; mon_px.addr = s_addr; mon_px.rgb = {s_r, s_g, s_b};
                s_px_q.push_back(mon_px);
            end
            if (fe)    begin mon_ev.cyc = cyc; mon_ev.val = fp;          fe_q.push_back(mon_ev);   end
            if (err)   begin mon_ev.cyc = cyc; mon_ev.val = {8'd0, code};   er_q.push_back(mon_ev);   end
            if (s_fe)  begin mon_ev.cyc = cyc; mon_ev.val = s_fp;        s_fe_q.push_back(mon_ev); end
            if (s_err) begin mon_ev.cyc = cyc; mon_ev.val = {8'd0, s_code}; s_er_q.push_back(mon_ev); end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus primitives and pixel-level model ----------------
    task automatic hold(input logic v, input int n);
        led_data = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: nominal 21/42 and 42/21; mode 1: random legal widths; mode 2: 30/31 highs
    task automatic send_bits(input logic [23:0] w, input int n, input int mode);
        int hi, lo;
        for (int i = 23; i > 23 - n; i--) begin
            case (mode)
                0:       begin hi = w[i] ? 42 : 21; lo = w[i] ? 21 : 42; end
                1:       begin hi = w[i] ? int'($urandom_range(35, 95)) : int'($urandom_range(8, 27));
                               lo = int'($urandom_range(8, 50)); end
                default: begin hi = w[i] ? 31 : 30; lo = 25; end
            endcase
            hold(1'b1, hi);
            last_fall_cyc = cyc;
            hold(1'b0, lo);
        end
    endtask

    task automatic send_pixel(input logic [23:0] grb, input int mode);
        px_t e;
        send_bits(grb, 24, mode);
        e.cyc  = 0;
        e.addr = 9'(frame_n);
        e.rgb  = {grb[15:8], grb[23:16], grb[7:0]};
        if (frame_n < DUT_LEDS) exp_px.push_back(e);
        frame_n++;
    endtask

    task automatic end_frame();
        hold(1'b0, GAP);
        exp_fe.push_back(frame_n);
        frame_n = 0;
    endtask

    task automatic clear_all();
        px_q.delete(); s_px_q.delete(); exp_px.delete();
        fe_q.delete(); er_q.delete(); s_fe_q.delete(); s_er_q.delete();
        exp_fe.delete();
        frame_n = 0;
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (px_q.size() != exp_px.size()) begin
            failures++;
            $display("FAIL %s strobe_count: got %0d expected %0d", tag, px_q.size(), exp_px.size());
        end else begin
            foreach (exp_px[i]) begin
                checks++;
                if (px_q[i].addr !== exp_px[i].addr || px_q[i].rgb !== exp_px[i].rgb) begin
                    failures++;
                    $display("FAIL %s pixel[%0d]: got addr=%0d rgb=%06h expected addr=%0d rgb=%06h",
                             tag, i, px_q[i].addr, px_q[i].rgb, exp_px[i].addr, exp_px[i].rgb);
                end
            end
        end
        checks++;
        if (fe_q.size() != exp_fe.size()) begin
            failures++;
            $display("FAIL %s frame_end_count: got %0d expected %0d", tag, fe_q.size(), exp_fe.size());
        end else begin
            foreach (exp_fe[i]) begin
                checks++;
                if (fe_q[i].val !== 10'(exp_fe[i])) begin
                    failures++;
                    $display("FAIL %s frame_pixels[%0d]: got %0d expected %0d", tag, i, fe_q[i].val, exp_fe[i]);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        led_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({r, g, b, addr, valid, fe, fp, err, code} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {r, g, b, addr, valid, fe, fp, err, code});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pixel();
        clear_all();
        hold(1'b0, GAP);
        send_pixel(24'h12A53C, 0);
        end_frame();
        checks++;
        if (px_q.size() != 1 || px_q[0].rgb !== 24'hA5123C || px_q[0].addr !== 9'd0) begin
            failures++;
            $display("FAIL single_pixel: got count=%0d rgb=%06h expected count=1 rgb=a5123c addr=0",
                     px_q.size(), (px_q.size() > 0) ? px_q[0].rgb : 24'h0);
        end
        checks++;
        if (fe_q.size() != 1 || fe_q[0].cyc - last_fall_cyc != 2503) begin
            failures++;
            $display("FAIL frame_end_timing: got count=%0d delay=%0d expected count=1 delay=2503",
                     fe_q.size(), (fe_q.size() > 0) ? fe_q[0].cyc - last_fall_cyc : -1);
        end
        checks++;
        if (fp !== 10'd1) begin
            failures++;
            $display("FAIL frame_pixels_held: got %0d expected 1", fp);
        end
        checks++;
        if (er_q.size() != 0) begin
            failures++;
            $display("FAIL single_no_error: got %0d errors expected 0", er_q.size());
        end
    endtask

    task automatic test_multi_frame();
        clear_all();
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom), 1);
        end_frame();
        for (int i = 0; i < 2; i++) send_pixel(24'($urandom), 1);
        end_frame();
        compare_model("multi_frame");
        checks++;
        if (er_q.size() != 0) begin
            failures++;
            $display("FAIL multi_no_error: got %0d errors expected 0", er_q.size());
        end
    endtask

    task automatic test_boundary();
        logic [23:0] w;
        clear_all();
        send_pixel(24'($urandom) | 24'h800001, 2);
        end_frame();
        compare_model("width_30_31");

        clear_all();
        w = 24'($urandom);
        send_bits(w, 10, 0);
        hold(1'b1, 4);
        hold(1'b0, 30);
        send_bits(w, 14, 0);
        send_bits(24'($urandom), 24, 0);
        hold(1'b0, GAP);
        checks++;
        if (er_q.size() != 1 || er_q[0].val !== 10'd0) begin
            failures++;
            $display("FAIL glitch_error: got count=%0d code=%0d expected count=1 code=0",
                     er_q.size(), (er_q.size() > 0) ? er_q[0].val : 10'h3ff);
        end
        checks++;
        if (px_q.size() != 0 || fe_q.size() != 0) begin
            failures++;
            $display("FAIL glitch_quiet: got strobes=%0d frame_ends=%0d expected 0 and 0",
                     px_q.size(), fe_q.size());
        end
        clear_all();
        send_pixel(24'($urandom), 1);
        end_frame();
        compare_model("glitch_resync");
    endtask

    task automatic test_stuck_high();
        int start;
        clear_all();
        start = cyc;
        hold(1'b1, 100);
        hold(1'b0, GAP);
        checks++;
        if (er_q.size() != 1 || er_q[0].val !== 10'd1) begin
            failures++;
            $display("FAIL stuck_error: got count=%0d code=%0d expected count=1 code=1",
                     er_q.size(), (er_q.size() > 0) ? er_q[0].val : 10'h3ff);
        end else begin
            checks++;
            if (er_q[0].cyc - start != 103) begin
                failures++;
                $display("FAIL stuck_timing: got %0d expected 103", er_q[0].cyc - start);
            end
        end
        checks++;
        if (fe_q.size() != 0) begin
            failures++;
            $display("FAIL stuck_no_frame_end: got %0d expected 0", fe_q.size());
        end
        clear_all();
        send_pixel(24'($urandom), 1);
        end_frame();
        compare_model("stuck_resync");
    endtask

    task automatic test_overflow();
        clear_all();
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom), 1);
        end_frame();
        compare_model("overflow_full_size");
        checks++;
        if (s_px_q.size() != 2) begin
            failures++;
            $display("FAIL overflow_strobes: got %0d expected 2", s_px_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (s_px_q[i].addr !== 9'(i) || s_px_q[i].rgb !== exp_px[i].rgb) begin
                    failures++;
                    $display("FAIL overflow_pixel[%0d]: got addr=%0d rgb=%06h expected addr=%0d rgb=%06h",
                             i, s_px_q[i].addr, s_px_q[i].rgb, i, exp_px[i].rgb);
                end
            end
        end
        checks++;
        if (s_er_q.size() != 1 || s_er_q[0].val !== 10'd3) begin
            failures++;
            $display("FAIL overflow_error: got count=%0d code=%0d expected count=1 code=3",
                     s_er_q.size(), (s_er_q.size() > 0) ? s_er_q[0].val : 10'h3ff);
        end else if (px_q.size() == 3) begin
            checks++;
            if (s_er_q[0].cyc != px_q[2].cyc) begin
                failures++;
                $display("FAIL overflow_timing: got cycle %0d expected %0d", s_er_q[0].cyc, px_q[2].cyc);
            end
        end
        checks++;
        if (s_fe_q.size() != 1 || s_fe_q[0].val !== 10'd3) begin
            failures++;
            $display("FAIL overflow_frame_pixels: got count=%0d value=%0d expected count=1 value=3",
                     s_fe_q.size(), (s_fe_q.size() > 0) ? s_fe_q[0].val : 10'h3ff);
        end

        clear_all();
        send_bits(24'($urandom), 10, 1);
        hold(1'b0, GAP);
        checks++;
        if (fe_q.size() != 1 || er_q.size() != 1) begin
            failures++;
            $display("FAIL partial_events: got frame_ends=%0d errors=%0d expected 1 and 1",
                     fe_q.size(), er_q.size());
        end else begin
            checks++;
            if (er_q[0].val !== 10'd2 || er_q[0].cyc != fe_q[0].cyc || fe_q[0].val !== 10'd0) begin
                failures++;
                $display("FAIL partial_error: got code=%0d err_cyc=%0d fe_cyc=%0d pixels=%0d expected code=2 same cycle pixels=0",
                         er_q[0].val, er_q[0].cyc, fe_q[0].cyc, fe_q[0].val);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_all();
        send_bits(24'($urandom), 12, 0);
        led_data = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({r, g, b, addr, valid, fe, fp, err, code} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {r, g, b, addr, valid, fe, fp, err, code});
        end
        rst_n = 1'b1;
        send_bits(24'($urandom), 24, 0);
        send_bits(24'($urandom), 24, 0);
        hold(1'b0, GAP);
        checks++;
        if (px_q.size() != 0 || fe_q.size() != 0 || er_q.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_quiet: got strobes=%0d frame_ends=%0d errors=%0d expected all 0",
                     px_q.size(), fe_q.size(), er_q.size());
        end
        clear_all();
        send_pixel(24'($urandom), 1);
        end_frame();
        compare_model("mid_reset_resync");
    endtask

    initial begin
        rst_n    = 1'b0;
        led_data = 1'b0;
        frame_n  = 0;
        test_reset();
        test_single_pixel();
        test_multi_frame();
        test_boundary();
        test_stuck_high();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
